// File: rtl/rob_pkg.sv
// Shared types and sizes for the reorder buffer and its pointer sub-module.
package rob_pkg;

  localparam int DEPTH      = 64;
  localparam int ROB_IDX_W  = $clog2(DEPTH);
  localparam int PREG_WIDTH = 6;
  localparam int AREG_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WB     = 3;
  localparam int PC_WIDTH   = 12;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  // Pointer carries one extra wrap bit above the index.
  typedef logic [ROB_IDX_W:0]   rob_ptr_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  reg_write;
    logic [AREG_WIDTH-1:0] areg;
    logic [PREG_WIDTH-1:0] preg;
    logic [PREG_WIDTH-1:0] old_preg;
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] data;
  } rob_entry_t;

  function automatic logic ptr_full(input rob_ptr_t head, input rob_ptr_t tail);
    return (head[ROB_IDX_W-1:0] == tail[ROB_IDX_W-1:0]) &&
           (head[ROB_IDX_W] != tail[ROB_IDX_W]);
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Circular pointer with wrap bit; increments on inc_en, load_en overrides.
module rob_ptr
  import rob_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     inc_en,
  input  logic     load_en,
  input  rob_ptr_t load_val,
  output rob_ptr_t ptr
);

  rob_ptr_t ptr_reg;
  rob_ptr_t ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (load_en) begin
      ptr_next = load_val;
    end else if (inc_en) begin
      ptr_next = ptr_reg + rob_ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete out of order, retire at head.
// Optional flush port is enabled by defining ROB_FLUSH_EN.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
`ifdef ROB_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         alloc_en,
  input  logic                         alloc_reg_write,
  input  logic [AREG_WIDTH-1:0]        alloc_areg,
  input  logic [PREG_WIDTH-1:0]        alloc_preg,
  input  logic [PREG_WIDTH-1:0]        alloc_old_preg,
  input  logic [PC_WIDTH-1:0]          alloc_pc,
  output logic                         alloc_ready,
  output logic [ROB_IDX_W-1:0]         rob_num,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*ROB_IDX_W-1:0]  wb_rob_idx,
  input  logic [NUM_WB*DATA_WIDTH-1:0] wb_data,
  output logic                         rob_empty,
  output logic                         commit_valid,
  output logic [AREG_WIDTH-1:0]        commit_areg,
  output logic [PREG_WIDTH-1:0]        commit_preg,
  output logic [DATA_WIDTH-1:0]        commit_data,
  output logic [PC_WIDTH-1:0]          commit_pc,
  output logic                         rob_push,
  output logic [PREG_WIDTH-1:0]        rob_free_reg
);

  rob_ptr_t   head_ptr;
  rob_ptr_t   tail_ptr;
  rob_idx_t   head_idx;
  rob_idx_t   tail_idx;
  logic       full;
  logic       flush_w;
  logic       alloc_fire;
  logic       retire_fire;
  logic       commit_fire;
  rob_entry_t head_entry;
  rob_entry_t entry_arr [DEPTH];

  logic                  commit_valid_reg;
  logic                  rob_push_reg;
  logic [AREG_WIDTH-1:0] commit_areg_reg;
  logic [PREG_WIDTH-1:0] commit_preg_reg;
  logic [DATA_WIDTH-1:0] commit_data_reg;
  logic [PC_WIDTH-1:0]   commit_pc_reg;
  logic [PREG_WIDTH-1:0] rob_free_reg_reg;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign head_idx    = head_ptr[ROB_IDX_W-1:0];
  assign tail_idx    = tail_ptr[ROB_IDX_W-1:0];
  assign full        = ptr_full(head_ptr, tail_ptr);
  assign alloc_ready = !full;
  assign rob_num     = tail_idx;
  assign rob_empty   = (head_ptr == tail_ptr);
  assign head_entry  = entry_arr[head_idx];

  assign alloc_fire  = alloc_en && !full && !flush_w;
  assign retire_fire = head_entry.valid && head_entry.done && !flush_w;
  assign commit_fire = retire_fire && head_entry.reg_write && (head_entry.areg != '0);

  rob_ptr u_head_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (retire_fire),
    .load_en  (1'b0),
    .load_val ('0),
    .ptr      (head_ptr)
  );

  // A flush collapses the tail back onto the head.
  rob_ptr u_tail_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (alloc_fire),
    .load_en  (flush_w),
    .load_val (head_ptr),
    .ptr      (tail_ptr)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      rob_entry_t ent_reg;
      rob_entry_t ent_next;

      // Later statements take priority: writeback < retire < alloc < flush.
      always_comb begin
        ent_next = ent_reg;
        for (int k = 0; k < NUM_WB; k++) begin
          if (wb_valid[k] && ent_reg.valid &&
              (wb_rob_idx[k*ROB_IDX_W +: ROB_IDX_W] == rob_idx_t'(gi))) begin
            ent_next.done = 1'b1;
            ent_next.data = wb_data[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        if (retire_fire && (head_idx == rob_idx_t'(gi))) begin
          ent_next.valid = 1'b0;
          ent_next.done  = 1'b0;
        end
        if (alloc_fire && (tail_idx == rob_idx_t'(gi))) begin
          ent_next.valid     = 1'b1;
          ent_next.done      = 1'b0;
          ent_next.reg_write = alloc_reg_write;
          ent_next.areg      = alloc_areg;
          ent_next.preg      = alloc_preg;
          ent_next.old_preg  = alloc_old_preg;
          ent_next.pc        = alloc_pc;
        end
        if (flush_w) begin
          ent_next.valid = 1'b0;
          ent_next.done  = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ent_reg <= '0;
        end else begin
          ent_reg <= ent_next;
        end
      end

      assign entry_arr[gi] = ent_reg;
    end
  endgenerate

  // Commit/free payload only changes on a pulse; strobes drop back every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_valid_reg <= 1'b0;
      rob_push_reg     <= 1'b0;
      commit_areg_reg  <= '0;
      commit_preg_reg  <= '0;
      commit_data_reg  <= '0;
      commit_pc_reg    <= '0;
      rob_free_reg_reg <= '0;
    end else begin
      commit_valid_reg <= commit_fire;
      rob_push_reg     <= commit_fire;
      if (commit_fire) begin
        commit_areg_reg  <= head_entry.areg;
        commit_preg_reg  <= head_entry.preg;
        commit_data_reg  <= head_entry.data;
        commit_pc_reg    <= head_entry.pc;
        rob_free_reg_reg <= head_entry.old_preg;
      end
    end
  end

  assign commit_valid = commit_valid_reg;
  assign rob_push     = rob_push_reg;
  assign commit_areg  = commit_areg_reg;
  assign commit_preg  = commit_preg_reg;
  assign commit_data  = commit_data_reg;
  assign commit_pc    = commit_pc_reg;
  assign rob_free_reg = rob_free_reg_reg;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer between the three ALU writeback ports and the architectural state.
- Dispatch allocates one entry per cycle and passes the returned index (rob_num) to the reservation station.
- ALUs mark entries complete out of order.
- Retires one completed head entry per cycle: drives ARF commit and returns the old physical register to the free pool (rob_push / rob_free_reg).

Parameters:
DEPTH, 64, number of entries; power of two; index width = log2(DEPTH) = 6
PREG_WIDTH, 6, physical register tag width
AREG_WIDTH, 5, architectural register index width
DATA_WIDTH, 32, result width
NUM_WB, 3, number of writeback ports (one per ALU)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
alloc_en  in  1  dispatch requests an entry this cycle
alloc_reg_write  in  1  instruction writes rd
alloc_areg  in  5  architectural rd
alloc_preg  in  6  new physical rd
alloc_old_preg  in  6  previous mapping of rd, freed at retire
alloc_pc  in  12  instruction PC
alloc_ready  out  1  entry available (!full)
rob_num  out  6  index the current allocation receives (= tail)
wb_valid  in  3  per-port completion strobe
wb_rob_idx  in  18  port k index in bits [6k+5:6k]
wb_data  in  96  port k result in bits [32k+31:32k]
rob_empty  out  1  no valid entries
commit_valid  out  1  one-cycle pulse: write commit_data to commit_areg
commit_areg  out  5  retired rd
commit_preg  out  6  retired physical rd
commit_data  out  32  retired result
commit_pc  out  12  retired PC
rob_push  out  1  one-cycle pulse: free rob_free_reg
rob_free_reg  out  6  old physical register being freed

Behaviour:
- State: head/tail pointers, 7 bits each (extra wrap bit); per-entry valid, done, reg_write, areg, preg, old_preg, pc, data.
- Reset (rst low, async): head = tail = 0; all valid/done cleared; commit_valid = rob_push = 0; all commit and free outputs = 0; rob_empty = 1; alloc_ready = 1; rob_num = 0.
- full when head/tail low bits equal and wrap bits differ; empty when head == tail.
- alloc_ready = !full, combinational from registered pointers; does not anticipate a same-cycle retire.
- Allocation: alloc_en && alloc_ready at edge → write entry at tail (valid = 1, done = 0), tail++.
  - alloc_en while full: ignored, no state change.
- Writeback: for each k with wb_valid[k] and entry valid → done = 1, data = wb_data[k].
  - Writeback to an invalid entry: ignored.
  - Two ports naming the same index: higher k wins (illegal in use; bench flags it).
  - Writeback to the entry being allocated in the same cycle: allocation wins (done = 0).
- Retire: at an edge where the head entry is valid && done, clear valid/done and head++.
  - Outputs are registered, valid in the following cycle for exactly one cycle.
  - Minimum latency: writeback at edge N → done; retire at edge N+1; commit_valid high after N+1.
- Retire with reg_write = 1 and areg != 0: commit_valid = 1, rob_push = 1, rob_free_reg = old_preg.
- Retire with reg_write = 0 or areg == 0: both pulses 0; head still advances.
- Simultaneous alloc, writeback and retire in one cycle are all legal and independent. A full ROB retiring this cycle still reports alloc_ready = 0 for that cycle.
- Pointer wrap from 63 to 0 toggles the wrap bit; there is no other special case.
- Outputs held when not pulsing: last values stay on commit_* / rob_free_reg; only the valid strobes return to 0.

Optional Feature:
ROB_FLUSH_EN:
- Defined: adds input port flush (1 bit). flush high at an edge clears all valid/done bits and sets tail = head; no retire that cycle.
  - Flush has priority over alloc, writeback and retire.
  - commit_valid and rob_push are 0 in the following cycle.
- Undefined: no flush port; entries leave only by retirement.

Decomposition:
- Package rob_pkg holds:
  - ROB_IDX_W, PREG_WIDTH, AREG_WIDTH, DATA_WIDTH, NUM_WB
  - rob_entry_t struct {valid, done, reg_write, areg, preg, old_preg, pc, data}
  - rob_idx_t typedef
- One sub-module, rob_ptr: a pointer register with a wrap bit and an increment enable. It is instantiated twice, for head and tail.

Test Plan:
- Reset then idle → rob_empty = 1, alloc_ready = 1, rob_num = 0, commit_valid = 0, rob_push = 0 for 10 cycles.
- Allocate areg 5 / preg 33 / old_preg 5 at idx 0, writeback port 1 idx 0 data 0xDEADBEEF → commit pulse 2 edges later: areg 5, preg 33, data 0xDEADBEEF; rob_push = 1 with rob_free_reg = 5.
- Allocate idx 0, 1, 2; writeback in order 2, 0, 1 on ports 2, 0, 1 → commits in order 0, 1, 2 on consecutive cycles.
- Allocate 64 entries → alloc_ready = 0; a 65th alloc_en is ignored; retire one → alloc_ready = 1 next cycle; next rob_num = 0 (wrap).
- Store (alloc_reg_write = 0) and x0 destination completing → head advances; commit_valid = 0 and rob_push = 0.
- With ROB_FLUSH_EN: 10 entries in flight, flush at the same edge as writeback to the head → rob_empty = 1 next cycle, no commit pulse; rst asserted mid-stream → all outputs at reset values immediately.
